// File: rtl/axi_stream_packet_arbiter.sv
// N:1 AXI-Stream arbiter with round-robin, packet-granular grants.
// The winning input is passed through combinationally; m_tid names it for downstream demux.
module axi_stream_packet_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int byte_width = 4,
    parameter int user_width = 1
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [NUM_INPUTS-1:0]                 s_tvalid,
    output logic [NUM_INPUTS-1:0]                 s_tready,
    input  logic [NUM_INPUTS*8*byte_width-1:0]    s_tdata,
    input  logic [NUM_INPUTS*byte_width-1:0]      s_tkeep,
    input  logic [NUM_INPUTS*byte_width-1:0]      s_tstrb,
    input  logic [NUM_INPUTS-1:0]                 s_tlast,
    input  logic [NUM_INPUTS*user_width-1:0]      s_tuser,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic [8*byte_width-1:0]               m_tdata,
    output logic [byte_width-1:0]                 m_tkeep,
    output logic [byte_width-1:0]                 m_tstrb,
    output logic                                  m_tlast,
    output logic [user_width-1:0]                 m_tuser,
    output logic [$clog2(NUM_INPUTS)-1:0]         m_tid,
    output logic                                  busy
);

    localparam int ID_W = $clog2(NUM_INPUTS);
    localparam int DW   = 8 * byte_width;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] grant, grant_next;
    logic [ID_W-1:0] last_grant, last_grant_next;
    logic [ID_W-1:0] pick;
    logic            found;

    logic [DW-1:0]         tdata_arr [NUM_INPUTS];
    logic [byte_width-1:0] tkeep_arr [NUM_INPUTS];
    logic [byte_width-1:0] tstrb_arr [NUM_INPUTS];
    logic [user_width-1:0] tuser_arr [NUM_INPUTS];

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
        assign tdata_arr[i] = s_tdata[i*DW +: DW];
        assign tkeep_arr[i] = s_tkeep[i*byte_width +: byte_width];
        assign tstrb_arr[i] = s_tstrb[i*byte_width +: byte_width];
        assign tuser_arr[i] = s_tuser[i*user_width +: user_width];
    end

    assign m_tdata = tdata_arr[grant];
    assign m_tkeep = tkeep_arr[grant];
    assign m_tstrb = tstrb_arr[grant];
    assign m_tuser = tuser_arr[grant];
    assign m_tlast = s_tlast[grant];
    assign m_tid   = grant;

    // Round-robin scan starting just after the previous winner, wrapping at NUM_INPUTS.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx   = last_grant;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = (idx == ID_W'(NUM_INPUTS - 1)) ? '0 : idx + 1'b1;
            if (!found && s_tvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Handshake: a beat moves when m_tvalid & m_tready; valid/ready of the granted source and
    // the sink are wired straight through, and s_tready never depends on any s_tvalid.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        m_tvalid        = 1'b0;
        s_tready        = '0;
        busy            = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = pick;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy            = 1'b1;
                m_tvalid        = s_tvalid[grant];
                s_tready[grant] = m_tready;
                if (m_tvalid && m_tready && m_tlast) begin
                    last_grant_next = grant;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_W'(NUM_INPUTS - 1);
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Directed bench for axi_stream_packet_arbiter: per-input source queues drive packets,
// a scoreboard of expected output beats is checked on every downstream handshake.
module tb_axi_stream_packet_arbiter;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int UW = 1;
    localparam int DW = 8 * BW;
    localparam int IW = 2;
    localparam int W  = IW + 1 + DW;

    logic            clk;
    logic            resetn;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*BW-1:0] s_tkeep;
    logic [N*BW-1:0] s_tstrb;
    logic [N-1:0]    s_tlast;
    logic [N*UW-1:0] s_tuser;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [BW-1:0]   m_tkeep;
    logic [BW-1:0]   m_tstrb;
    logic            m_tlast;
    logic [UW-1:0]   m_tuser;
    logic [IW-1:0]   m_tid;
    logic            busy;

    logic [W-1:0]  exp_q[$];
    logic [DW:0]   src_q[N][$];
    logic [N-1:0]  src_en;
    int            checks = 0;
    int            failures = 0;

    axi_stream_packet_arbiter #(
        .NUM_INPUTS(N),
        .byte_width(BW),
        .user_width(UW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tdata(s_tdata),
        .s_tkeep(s_tkeep),
        .s_tstrb(s_tstrb),
        .s_tlast(s_tlast),
        .s_tuser(s_tuser),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata(m_tdata),
        .m_tkeep(m_tkeep),
        .m_tstrb(m_tstrb),
        .m_tlast(m_tlast),
        .m_tuser(m_tuser),
        .m_tid(m_tid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // keep/strb/user are derived from the data word so every field identifies its source beat.
    task automatic drive_inputs();
        logic [DW:0] beat;
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                beat = src_q[i][0];
                s_tvalid[i]           = 1'b1;
                s_tdata[i*DW +: DW]   = beat[DW-1:0];
                s_tlast[i]            = beat[DW];
                s_tkeep[i*BW +: BW]   = beat[3:0];
                s_tstrb[i*BW +: BW]   = beat[7:4];
                s_tuser[i]            = beat[8];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic add_pkt(input int src, input int nbeats);
        logic [DW-1:0] d;
        logic          last;
        for (int b = 0; b < nbeats; b++) begin
            d    = $urandom;
            last = (b == nbeats - 1);
            src_q[src].push_back({last, d});
            exp_q.push_back({IW'(src), last, d});
        end
    endtask

    // One clock: observe handshakes at the falling edge, update sources just after the rising edge.
    task automatic tick();
        logic [N-1:0] hs;
        logic [W-1:0] e;
        logic [DW:0]  dropped;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            chk("beat_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_tid",  m_tid,   e[W-1 -: IW]);
                chk("beat_last", m_tlast, e[DW]);
                chk("beat_data", m_tdata, e[DW-1:0]);
                chk("beat_keep", m_tkeep, e[3:0]);
                chk("beat_strb", m_tstrb, e[7:4]);
                chk("beat_user", m_tuser, e[8]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) dropped = src_q[i].pop_front();
        end
        drive_inputs();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_reached", 64'(exp_q.size() == 0 && busy === 1'b0), 1);
    endtask

    initial begin
        int         order [5];
        logic [W-1:0] held;
        order = '{0, 1, 2, 3, 0};

        resetn   = 1'b0;
        m_tready = 1'b1;
        src_en   = '0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tstrb  = '0;
        s_tlast  = '0;
        s_tuser  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy",   busy,     0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_sready", s_tready, 0);
        chk("rst_tid",    m_tid,    0);

        // Single 3-beat packet on input 2
        resetn = 1'b1;
        src_en = 4'b0100;
        add_pkt(2, 3);
        drive_inputs();
        chk("t1_idle_mvalid", m_tvalid, 0);
        tick();
        chk("t1_busy",   busy,     1);
        chk("t1_tid",    m_tid,    2);
        chk("t1_mvalid", m_tvalid, 1);
        chk("t1_sready", s_tready, 4'b0100);
        tick();
        tick();
        tick();
        chk("t1_done_busy",   busy,     0);
        chk("t1_done_mvalid", m_tvalid, 0);
        chk("t1_done_exp",    exp_q.size(), 0);

        // All inputs requesting 1-beat packets: strict rotation with one bubble per packet
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) add_pkt(order[k], 1);
        src_en = 4'b1111;
        drive_inputs();
        chk("t2_mvalid_0", m_tvalid, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t2_mvalid_pattern", m_tvalid, k % 2);
            if (k % 2 == 1) chk("t2_rr_order", m_tid, order[k/2]);
        end
        wait_idle(20);

        // Input 1 owns a 4-beat packet; input 3 arrives mid-packet and must wait
        src_en = 4'b0010;
        add_pkt(1, 4);
        add_pkt(3, 1);
        drive_inputs();
        tick();
        chk("t3_tid_first", m_tid, 1);
        tick();
        src_en[3] = 1'b1;
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            chk("t3_sready3_blocked", s_tready[3], 0);
            chk("t3_tid_held",        m_tid,       1);
            tick();
        end
        chk("t3_gap_busy",   busy,     0);
        chk("t3_gap_sready", s_tready, 0);
        tick();
        chk("t3_tid_next", m_tid,    3);
        chk("t3_sready3",  s_tready, 4'b1000);
        wait_idle(20);

        // Downstream stall for 5 cycles mid-packet
        src_en = 4'b0001;
        add_pkt(0, 3);
        drive_inputs();
        tick();
        tick();
        m_tready = 1'b0;
        held = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_data_stable", m_tdata,  held[DW-1:0]);
            chk("t4_last_stable", m_tlast,  held[DW]);
            chk("t4_tid_stable",  m_tid,    0);
            chk("t4_sready_low",  s_tready, 0);
            chk("t4_busy_held",   busy,     1);
        end
        m_tready = 1'b1;
        wait_idle(20);

        // Reset pulse on beat 2 abandons the packet; priority returns to input 0
        src_en = 4'b1000;
        add_pkt(3, 4);
        drive_inputs();
        tick();
        tick();
        chk("t5_tid_before", m_tid, 3);
        chk("t5_busy_before", busy, 1);
        resetn = 1'b0;
        src_q[3].delete();
        exp_q.delete();
        add_pkt(0, 1);
        add_pkt(1, 1);
        src_en = 4'b0011;
        drive_inputs();
        tick();
        chk("t5_rst_mvalid", m_tvalid, 0);
        chk("t5_rst_busy",   busy,     0);
        chk("t5_rst_sready", s_tready, 0);
        resetn = 1'b1;
        tick();
        chk("t5_tid_after", m_tid,    0);
        chk("t5_mvalid",    m_tvalid, 1);
        wait_idle(20);

        chk("final_exp_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
